// File: rtl/judge3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : judge3_pkg
//  Purpose  : Shared types and constants for the judge3 self-check engine.
//  Revision : 1.0  initial release
// ============================================================================
package judge3_pkg;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Number of input combinations of a 3-input judge
   localparam int NUM_VEC = 8;

   // Expected majority response indexed by pattern {a,b,c}
   localparam logic [NUM_VEC-1:0] JUDGE3_EXP = 8'hE8;

   // Reference majority of three bits
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage : judge3_pkg
`default_nettype wire

// File: rtl/judge3_golden.sv
`default_nettype none
// ============================================================================
//  Module   : judge3_golden
//  Purpose  : Combinational golden majority-of-three used as the reference.
//  Revision : 1.0  initial release
// ============================================================================
module judge3_golden
   import judge3_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   output logic maj
);

   // Reference response for the current stimulus pattern
   assign maj = maj3(a, b, c);

endmodule : judge3_golden
`default_nettype wire

// File: rtl/judge3_checker.sv
`default_nettype none
// ============================================================================
//  Module   : judge3_checker
//  Purpose  : Sweeps all eight input patterns into a judge3 instance, waits
//             SETTLE cycles per vector, samples the response and compares it
//             with a golden majority. Reports per-vector failures and pass.
//  Options  : JUDGE3_CHK_STOP_EN - stop the sweep on the first mismatch.
//  Revision : 1.0  initial release
// ============================================================================
module judge3_checker
   import judge3_pkg::*;
#(
   parameter int SETTLE = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [7:0] fail_vec
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] pattern;
   logic [3:0] settle_cnt;
   logic       exp_bit;
   logic       mismatch;
   logic       stop_now;
   logic [3:0] err_next;

   judge3_golden u_golden (
      .a   (pattern[2]),
      .b   (pattern[1]),
      .c   (pattern[0]),
      .maj (exp_bit)
   );

   // Case-inequality so an undriven or unknown response counts as a failure
   assign mismatch = (dut_out !== exp_bit);
   assign err_next = err_cnt + {3'b000, mismatch};

`ifdef JUDGE3_CHK_STOP_EN
   assign stop_now = mismatch;
`else
   assign stop_now = 1'b0;
`endif

   // Stimulus is taken straight from the pattern register
   assign in1 = pattern[2];
   assign in2 = pattern[1];
   assign in3 = pattern[0];

   // Sweep sequencer with registered status and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pattern    <= 4'd0;
         settle_cnt <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= 4'd0;
         fail_vec   <= 8'd0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_SETTLE;
                  pattern    <= 4'd0;
                  settle_cnt <= 4'd0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_cnt    <= 4'd0;
                  fail_vec   <= 8'd0;
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (mismatch) begin
                  fail_vec[pattern[2:0]] <= 1'b1;
               end
               err_cnt <= err_next;
               // Termination uses the explicit last-pattern compare
               if ((pattern == 4'd7) || stop_now) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 4'd0);
               end else begin
                  pattern    <= pattern + 4'd1;
                  settle_cnt <= 4'd0;
                  state      <= ST_SETTLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : judge3_checker
`default_nettype wire

// File: tb/tb_judge3_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_judge3_checker
//  Purpose  : Directed self-checking bench for judge3_checker with a
//             selectable behavioural DUT (majority, stuck-at-0, XOR3).
//  Options  : JUDGE3_CHK_STOP_EN - expectations follow the stop-on-fail build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_judge3_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       dut_out;
   logic       in1, in2, in3;
   logic       busy, done, pass;
   logic [3:0] err_cnt;
   logic [7:0] fail_vec;

   int checks = 0;
   int errors = 0;
   int mode   = 0;   // 0 majority, 1 stuck-at-0, 2 XOR3

   judge3_checker #(.SETTLE(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dut_out  (dut_out),
      .in1      (in1),
      .in2      (in2),
      .in3      (in3),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_cnt  (err_cnt),
      .fail_vec (fail_vec)
   );

   always #5 clk = ~clk;

   // Behavioural device under check
   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0:       dut_out = (in1 & in2) | (in1 & in3) | (in2 & in3);
         1:       dut_out = 1'b0;
         default: dut_out = in1 ^ in2 ^ in3;
      endcase
   end

   // Pulse start for one edge; returns #1 after edge k
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after edge k until done rises (bounded at 200)
   task automatic wait_done(input int n_in, output int n);
      n = n_in;
      while (!done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      checks++;
      if ({in1, in2, in3} !== 3'b000) begin errors++; $display("FAIL reset_stim got %b want 000", {in1, in2, in3}); end
      checks++;
      if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
      checks++;
      if (err_cnt !== 4'd0 || fail_vec !== 8'h00) begin errors++; $display("FAIL reset_results got %0d/%h want 0/00", err_cnt, fail_vec); end
      rst = 1'b0;
   endtask

   task automatic test_pass_sweep();
      int n;
      mode = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || {in1, in2, in3} !== 3'b000) begin errors++; $display("FAIL pass_first got busy=%b stim=%b want 1/000", busy, {in1, in2, in3}); end
      wait_done(0, n);
      checks++;
      if (n !== 40) begin errors++; $display("FAIL pass_latency got %0d want 40", n); end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 4'd0 || fail_vec !== 8'h00) begin errors++; $display("FAIL pass_results got %b/%0d/%h want 1/0/00", pass, err_cnt, fail_vec); end
      checks++;
      if ({in1, in2, in3} !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL pass_hold got %b busy=%b want 111/0", {in1, in2, in3}, busy); end
   endtask

   task automatic test_stuck0();
      int n;
      mode = 1;
      pulse_start();
      wait_done(0, n);
`ifdef JUDGE3_CHK_STOP_EN
      checks++;
      if (n !== 20) begin errors++; $display("FAIL stuck0_latency got %0d want 20", n); end
      checks++;
      if ({in1, in2, in3} !== 3'b011) begin errors++; $display("FAIL stuck0_stim got %b want 011", {in1, in2, in3}); end
      checks++;
      if (err_cnt !== 4'd1 || fail_vec !== 8'h08 || pass !== 1'b0) begin errors++; $display("FAIL stuck0_results got %0d/%h/%b want 1/08/0", err_cnt, fail_vec, pass); end
`else
      checks++;
      if (n !== 40) begin errors++; $display("FAIL stuck0_latency got %0d want 40", n); end
      checks++;
      if (err_cnt !== 4'd4 || fail_vec !== 8'hE8 || pass !== 1'b0) begin errors++; $display("FAIL stuck0_results got %0d/%h/%b want 4/e8/0", err_cnt, fail_vec, pass); end
`endif
   endtask

   task automatic test_xor3();
      int n;
      mode = 2;
      pulse_start();
      wait_done(0, n);
`ifdef JUDGE3_CHK_STOP_EN
      checks++;
      if (n !== 10 || err_cnt !== 4'd1 || fail_vec !== 8'h02 || pass !== 1'b0) begin errors++; $display("FAIL xor3_results got n=%0d %0d/%h/%b want 10 1/02/0", n, err_cnt, fail_vec, pass); end
`else
      checks++;
      if (n !== 40) begin errors++; $display("FAIL xor3_latency got %0d want 40", n); end
      checks++;
      if (err_cnt !== 4'd6 || fail_vec !== 8'h7E || pass !== 1'b0) begin errors++; $display("FAIL xor3_results got %0d/%h/%b want 6/7e/0", err_cnt, fail_vec, pass); end
`endif
   endtask

   task automatic test_back_to_back();
      int n;
      mode = 0;
      pulse_start();
      repeat (12) begin @(posedge clk); #1; end
      // start while busy must be ignored
      pulse_start();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midstart_busy got busy=%b done=%b want 1/0", busy, done); end
      wait_done(13, n);
      checks++;
      if (n !== 40 || pass !== 1'b1) begin errors++; $display("FAIL midstart_latency got n=%0d pass=%b want 40/1", n, pass); end
      // restart from DONE clears results and begins at pattern 000
      mode = 1;
      pulse_start();
      checks++;
      if ({done, pass, busy} !== 3'b001 || err_cnt !== 4'd0 || fail_vec !== 8'h00) begin errors++; $display("FAIL restart_clear got dpb=%b %0d/%h want 001 0/00", {done, pass, busy}, err_cnt, fail_vec); end
      checks++;
      if ({in1, in2, in3} !== 3'b000) begin errors++; $display("FAIL restart_stim got %b want 000", {in1, in2, in3}); end
      wait_done(0, n);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
   endtask

   task automatic test_async_reset();
      int n;
      int guard;
      mode = 0;
      pulse_start();
      guard = 0;
      while ({in1, in2, in3} !== 3'b011 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if ({in1, in2, in3} !== 3'b011) begin errors++; $display("FAIL areset_reach got %b want 011", {in1, in2, in3}); end
      repeat (2) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in1, in2, in3, busy, done, pass} !== 6'b0 || err_cnt !== 4'd0 || fail_vec !== 8'h00) begin errors++; $display("FAIL areset_outputs got %b %0d/%h want 000000 0/00", {in1, in2, in3, busy, done, pass}, err_cnt, fail_vec); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_idle got busy=%b done=%b want 0/0", busy, done); end
      pulse_start();
      checks++;
      if ({in1, in2, in3} !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL areset_restart got %b busy=%b want 000/1", {in1, in2, in3}, busy); end
      wait_done(0, n);
      checks++;
      if (n !== 40 || pass !== 1'b1) begin errors++; $display("FAIL areset_sweep got n=%0d pass=%b want 40/1", n, pass); end
   endtask

   initial begin
      test_reset();
      test_pass_sweep();
      test_stuck0();
      test_xor3();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_judge3_checker
`default_nettype wire
